// File: rtl/cpu0_mem_pkg.sv
// cpu0_mem_pkg: shared types and constants for the cpu0 memory bus arbiter.
// Width codes, memory/IO window defaults, the arbiter state encoding, the
// latched request-field struct and the address decode helper.
package cpu0_mem_pkg;

  // Operand width codes as seen on size*/m_size.
  localparam logic [1:0] BYTE  = 2'd0;
  localparam logic [1:0] INT16 = 2'd1;
  localparam logic [1:0] INT24 = 2'd2;
  localparam logic [1:0] INT32 = 2'd3;

  localparam logic [31:0] MEMSIZE_DEFAULT = 32'h0008_0000;
  localparam logic [31:0] IOADDR_DEFAULT  = 32'h0008_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // What an address turns into once decoded.
  typedef enum logic [1:0] {
    K_MEM = 2'd0,
    K_IO  = 2'd1,
    K_ERR = 2'd2
  } kind_t;

  typedef struct packed {
    logic        rw;     // 1 = read, 0 = write
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_fields_t;

  // The IO port wins over the range check: IOADDR sits right at the top of
  // the array, so it would otherwise decode as out of range.
  function automatic kind_t decode_kind(input logic [31:0] addr,
                                        input logic [31:0] memsize,
                                        input logic [31:0] ioaddr);
    if (addr == ioaddr)            return K_IO;
    if (addr > memsize - 32'd4)    return K_ERR;
    return K_MEM;
  endfunction

endpackage

// File: rtl/cpu0_rr_pick2.sv
// cpu0_rr_pick2: combinational two-way round-robin winner select.
//   req  : request vector, bit n = port n
//   last : port served most recently (loses a tie)
//   excl : ports that may not win this cycle
//   win  : winning port index
//   vld  : some eligible port is requesting
module cpu0_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] excl,
  output logic       win,
  output logic       vld
);

  logic [1:0] eff;

  always_comb begin
    eff = req & ~excl;
    vld = |eff;
    win = 1'b0;
    case (eff)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last;
      default: win = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu0_mem_arbiter.sv
// cpu0_mem_arbiter: serialises two bus masters onto memory0.
//   clock, reset (async, active-low)
//   port n: req/rw/size/addr/wdata in, gnt/ack out; shared rdata/err
//   io_wr/io_data : write strobe and data for the output port at IOADDR
//   m_en/m_rw/m_size/m_abus/m_dout out, m_din in : memory0 interface
//   dbg_state     : current FSM state (state_t encoding)
//
// Handshake: a master raises req with its fields and holds req until it sees
// its one-cycle ack; the fields are latched at grant, so they may change
// freely afterwards. gnt marks bus ownership, ack (qualified by err) marks
// completion, and rdata is valid in the ack cycle and held until the next ack.
module cpu0_mem_arbiter
  import cpu0_mem_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter logic [31:0] MEMSIZE = MEMSIZE_DEFAULT,
  parameter logic [31:0] IOADDR  = IOADDR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        rw0,
  input  logic        rw1,
  input  logic [1:0]  size0,
  input  logic [1:0]  size1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        err,
  output logic        io_wr,
  output logic [31:0] io_data,
  output logic        m_en,
  output logic        m_rw,
  output logic [1:0]  m_size,
  output logic [31:0] m_abus,
  output logic [31:0] m_dout,
  input  logic [31:0] m_din,
  output logic [1:0]  dbg_state
);

  state_t      state;
  req_fields_t cur;        // fields of the access in flight (or pending)
  kind_t       cur_kind;
  logic        owner;      // port that owns cur
  logic        last;       // last-served port
  logic [2:0]  cnt;        // m_en cycles remaining after this one

  req_fields_t in0, in1, win_f, launch_f;
  kind_t       win_kind, launch_kind;
  logic [1:0]  excl;
  logic        win, win_vld;

  assign in0 = '{rw: rw0, size: size0, addr: addr0, wdata: wdata0};
  assign in1 = '{rw: rw1, size: size1, addr: addr1, wdata: wdata1};
  assign win_f    = win ? in1 : in0;
  assign win_kind = decode_kind(win_f.addr, MEMSIZE, IOADDR);

  // While an access is in flight only the other port may be picked; this is
  // also what makes the just-acked port's req invisible in its ack cycle.
  assign excl = (state == ST_ACCESS) ? (owner ? 2'b10 : 2'b01) : 2'b00;

  cpu0_rr_pick2 u_pick (
    .req  ({req1, req0}),
    .last (last),
    .excl (excl),
    .win  (win),
    .vld  (win_vld)
  );

  // Fields entering ACCESS: fresh from the winner in IDLE, or the pending
  // grant latched during the previous owner's last ACCESS cycle.
  always_comb begin
    launch_f    = cur;
    launch_kind = cur_kind;
    if (state == ST_IDLE) begin
      launch_f    = win_f;
      launch_kind = win_kind;
    end
  end

  assign dbg_state = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cur      <= '0;
      cur_kind <= K_MEM;
      owner    <= 1'b0;
      last     <= 1'b1;
      cnt      <= 3'd0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err      <= 1'b0;
      io_wr    <= 1'b0;
      io_data  <= 32'h0;
      rdata    <= 32'h0;
      m_en     <= 1'b0;
      m_rw     <= 1'b1;
      m_size   <= INT32;
      m_abus   <= 32'h0;
      m_dout   <= 32'h0;
    end else begin
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      err   <= 1'b0;
      io_wr <= 1'b0;

      // Entering ACCESS from IDLE or DONE: drive the memory only for
      // addresses that decode into the array.
      if ((state == ST_IDLE && win_vld) || (state == ST_DONE && (gnt0 || gnt1))) begin
        cnt <= 3'(MEM_LAT - 1);
        if (launch_kind == K_MEM) begin
          m_en   <= 1'b1;
          m_rw   <= launch_f.rw;
          m_size <= launch_f.size;
          m_abus <= launch_f.addr;
          m_dout <= launch_f.wdata;
        end
      end

      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            cur      <= win_f;
            cur_kind <= win_kind;
            owner    <= win;
            gnt0     <= ~win;
            gnt1     <= win;
            state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cur_kind == K_MEM && cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            m_en <= 1'b0;
            case (cur_kind)
              K_MEM: if (cur.rw) rdata <= m_din;
              K_IO: begin
                if (cur.rw) begin
                  rdata <= 32'h0;
                end else begin
                  io_wr   <= 1'b1;
                  io_data <= cur.wdata;
                end
              end
              default: err <= 1'b1;
            endcase
            ack0  <= ~owner;
            ack1  <= owner;
            last  <= owner;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            state <= ST_DONE;
            // Hand the bus to the other port so its gnt shows in this ack cycle.
            if (win_vld) begin
              cur      <= win_f;
              cur_kind <= win_kind;
              owner    <= win;
              gnt0     <= ~win;
              gnt1     <= win;
            end
          end
        end
        ST_DONE: begin
          state <= (gnt0 || gnt1) ? ST_ACCESS : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpu0_mem_arbiter.md
# cpu0_mem_arbiter

Two-port memory bus arbiter between `cpu0` (port 0) and a second bus master such as the flash loader or a DMA engine (port 1), in front of `memory0`. It serialises the two masters onto the single `en/rw/m_size/abus/dbus` interface with round-robin fairness and holds each grant for a whole access. It decodes the IO window at `IOADDR` and the out-of-range space so that neither reaches the memory array.

## Interface
- `MEM_LAT`, 1: cycles `m_en` is held per access (1..7).
- `MEMSIZE`, 'h80000: top of the memory array in bytes.
- `IOADDR`, 'h80000: word address of the output port.
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `req0`/`req1` in 1: access request; held until `ack` is seen.
- `rw0`/`rw1` in 1: 1 = read, 0 = write.
- `size0`/`size1` in 2: operand width (`BYTE`/`INT16`/`INT24`/`INT32`).
- `addr0`/`addr1` in 32: byte address.
- `wdata0`/`wdata1` in 32: write data.
- `gnt0`/`gnt1` out 1: high while that port owns the bus.
- `ack0`/`ack1` out 1: one-cycle completion pulse.
- `rdata` out 32: read data; valid in the `ack` cycle; holds until the next `ack`.
- `err` out 1: qualifies `ack`; access was out of range.
- `io_wr` out 1: one-cycle strobe for a write to `IOADDR`.
- `io_data` out 32: write data that accompanies `io_wr`.
- `m_en`, `m_rw` out 1 each: memory enable and direction.
- `m_size` out 2: memory access width.
- `m_abus` out 32: memory address.
- `m_dout` out 32: data to memory (`dbus_in`).
- `m_din` in 32: data from memory (`dbus_out`).

## Operation
- The FSM has three states: IDLE, ACCESS and DONE. Outputs are registered.
- **IDLE**
  - If any `req` is high, pick the winner, latch its `rw/size/addr/wdata`, set its `gnt`, and go to ACCESS.
  - Otherwise stay in IDLE.
- **Winner selection:** when both requests are high, the port not served last wins. The last-served pointer resets to 1, so port 0 wins the first tie.
- **ACCESS**
  - Address decode takes priority over the memory access:
    - `addr == IOADDR`: `m_en` stays 0. A write pulses `io_wr` with `io_data = wdata`; a read returns `rdata = 0`. Go to DONE after 1 cycle.
    - `addr > MEMSIZE-4` (other than `IOADDR`): `m_en` stays 0, `err = 1`, `rdata` is unchanged. Go to DONE after 1 cycle.
    - Otherwise: drive `m_en = 1` with `m_rw/m_size/m_abus/m_dout` from the latched fields for `MEM_LAT` cycles (down-counter). On the last cycle, reads capture `m_din` into `rdata`. Then go to DONE.
- **DONE**
  - Pulse the owner's `ack` (with `err` if set), drop its `gnt`, and update the last-served pointer.
  - If the other port is requesting, grant it and go straight to ACCESS; otherwise go to IDLE.
  - The just-acked port's `req` is ignored in this cycle. If it is still high next cycle, it is treated as a new request.
- **Request withdrawn after grant:** the access still completes and `ack` still pulses.
- **Field stability:** changes to `addr`/`wdata` after the grant have no effect, because the fields were latched.
- **Write data:** `m_dout` carries the full 32 bits. `memory0` selects the bytes according to `m_size`.

## Timing
- Reset values: state IDLE; pointer = 1; `gnt*`, `ack*`, `err`, `io_wr`, `m_en` = 0; `m_rw` = 1; `m_size` = `INT32`; `m_abus`, `m_dout`, `rdata`, `io_data` = 0.
- **Single access:** `req` high at edge N gives `gnt` and `m_en` from N+1, `m_en` low at N+1+`MEM_LAT`, and `ack` at N+1+`MEM_LAT`. Request-to-ack latency is `MEM_LAT`+1 cycles; with the default this is 2 cycles, the same as cpu0's Execute→WriteBack.
- **IO and error accesses:** latency is 2 cycles regardless of `MEM_LAT`.
- **Back-to-back, alternating ports:** one access every `MEM_LAT`+1 cycles, with no idle cycle between them.
- **Same port repeatedly:** one access every `MEM_LAT`+2 cycles.
- **Reset asserted mid-access:** `m_en` drops asynchronously, no `ack` is issued, and the pending transaction is discarded.
- `gnt0` and `gnt1` are never high together. `m_en` is never high outside ACCESS.

## Structure
- Package `cpu0_mem_pkg` holds:
  - width codes `INT32`/`INT24`/`INT16`/`BYTE`;
  - `MEMSIZE` and `IOADDR` defaults;
  - the state encoding (IDLE = 0, ACCESS = 1, DONE = 2);
  - a request-field struct (`rw`, `size`, `addr`, `wdata`).
- Sub-module `cpu0_rr_pick2`: combinational winner select from `req[1:0]`, the last-served pointer and an exclude mask. The FSM, counter and decode stay in the top module.

## Test plan
- Reset, then port 0 reads `INT32` at 'h100 where memory holds 'h12345678: `m_en` high 1 cycle, `ack0` at cycle 2, `rdata` = 'h12345678, `err` = 0.
- Both requesters raise `req` in the same cycle: port 0 writes 'hAA (`BYTE`) to 'h200, port 1 reads `INT32` from 'h200:
  - `gnt0` first, `gnt1` in port 0's `ack` cycle;
  - port 1 `rdata` = 'hAAxxxxxx (the byte at 'h200 is the MSB);
  - `gnt`s are never simultaneous.
- Both hold `req` continuously for 6 accesses: grants alternate 0,1,0,1,0,1, with an `ack` every 2 cycles.
- Port 1 writes 'h00006948 to `IOADDR`: `io_wr` pulses once with `io_data` = 'h00006948, `m_en` stays 0, and `ack1` arrives after 2 cycles.
- Port 0 reads at 'h80004: `ack0` with `err` = 1, `m_en` never asserts, and `rdata` is unchanged.
- `MEM_LAT` = 3, reset driven low in the second `m_en` cycle: all outputs return to reset values immediately. After release, a new `req0` completes normally with 4-cycle latency.
